// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter.
//   arb_state_e : init-sweep / run state of the arbiter FSM
//   PORT_W      : width of a requester index
//   rsp_tag_t   : tag carried alongside a RAM command so the read data
//                 can be routed back to the port that issued it
package ram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    localparam int PORT_W = 1;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic              is_read;
    } rsp_tag_t;

    // One-hot request/response vector for a port index.
    function automatic logic [1:0] port_onehot(input logic [PORT_W-1:0] p);
        logic [1:0] oh;
        if (p == 1'b1) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : grants may only be issued while high
//   valid[1:0]  : per-port request valid
//   grant[1:0]  : one-hot combinational grant (a grant always means a transfer,
//                 since it is only given to a valid port)
//   grant_port  : index of the granted port, meaningful when grant != 0
// After every transfer the other port gets priority on the next conflict.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        valid,
    output logic [1:0]        grant,
    output logic [PORT_W-1:0] grant_port
);

    logic [PORT_W-1:0] prio_r;
    logic [1:0]        grant_s;
    logic [PORT_W-1:0] port_s;

    // Grant decode: a lone requester wins, a conflict goes to the priority port.
    always_comb begin
        grant_s = 2'b00;
        port_s  = prio_r;
        if (en) begin
            case (valid)
                2'b01: begin
                    grant_s = 2'b01;
                    port_s  = 1'b0;
                end
                2'b10: begin
                    grant_s = 2'b10;
                    port_s  = 1'b1;
                end
                2'b11: begin
                    grant_s = port_onehot(prio_r);
                    port_s  = prio_r;
                end
                default: begin
                    grant_s = 2'b00;
                    port_s  = prio_r;
                end
            endcase
        end else begin
            grant_s = 2'b00;
            port_s  = prio_r;
        end
    end

    // Priority register: flips to the loser after each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (grant_s != 2'b00) begin
            prio_r <= ~port_s;
        end else begin
            prio_r <= prio_r;
        end
    end

    assign grant      = grant_s;
    assign grant_port = port_s;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between two requesters.
// After reset the whole RAM is cleared to INIT_VAL, then requests are
// arbitrated round-robin. A transfer at edge k drives the RAM during
// cycle k+1; read data is returned on rsp_rdata with a one-cycle
// rsp_valid pulse at edge k+2.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/ready/we  : per-port handshake and op (1 = write)
//   req_addr/req_wdata  : per-port fields, port i in slice [i*W +: W]
//   rsp_valid/rsp_rdata : read response
//   ram_*               : registered RAM control, ram_rdata from the RAM
//   init_done           : high once the clear sweep has completed
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                 ADDR_W   = 10,
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    arb_state_e        state_r;
    logic [ADDR_W-1:0] init_addr_r;
    logic              init_done_r;

    logic              ram_cs_r;
    logic              ram_we_r;
    logic              ram_re_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_wdata_r;

    rsp_tag_t          cmd_tag_r;   // tag of the command on the RAM pins
    rsp_tag_t          ram_tag_r;   // tag of the command the RAM just executed
    logic [1:0]        rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    logic [1:0]        grant_s;
    logic [PORT_W-1:0] grant_port_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_r == ST_RUN),
        .valid      (req_valid),
        .grant      (grant_s),
        .grant_port (grant_port_s)
    );

    // Mux the granted port's fields onto the command path.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (grant_port_s == 1'b1) begin
            sel_we_s    = req_we[1];
            sel_addr_s  = req_addr[2*ADDR_W-1:ADDR_W];
            sel_wdata_s = req_wdata[2*DATA_W-1:DATA_W];
        end else begin
            sel_we_s    = req_we[0];
            sel_addr_s  = req_addr[ADDR_W-1:0];
            sel_wdata_s = req_wdata[DATA_W-1:0];
        end
    end

    // Init/run FSM and the RAM command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            init_addr_r <= '0;
            init_done_r <= 1'b0;
            ram_cs_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_re_r    <= 1'b0;
            ram_addr_r  <= '0;
            ram_wdata_r <= '0;
            cmd_tag_r   <= '0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    ram_cs_r    <= 1'b1;
                    ram_we_r    <= 1'b1;
                    ram_re_r    <= 1'b0;
                    ram_addr_r  <= init_addr_r;
                    ram_wdata_r <= INIT_VAL;
                    cmd_tag_r   <= '0;
                    init_addr_r <= init_addr_r + ADDR_ONE;
                    init_done_r <= 1'b0;
                    if (init_addr_r == LAST_ADDR) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                ST_RUN: begin
                    state_r     <= ST_RUN;
                    init_addr_r <= init_addr_r;
                    init_done_r <= 1'b1;
                    if (grant_s != 2'b00) begin
                        ram_cs_r          <= 1'b1;
                        ram_we_r          <= sel_we_s;
                        ram_re_r          <= ~sel_we_s;
                        ram_addr_r        <= sel_addr_s;
                        ram_wdata_r       <= sel_wdata_s;
                        cmd_tag_r.port    <= grant_port_s;
                        cmd_tag_r.is_read <= ~sel_we_s;
                    end else begin
                        // Address/data hold so the RAM pins do not toggle when idle.
                        ram_cs_r          <= 1'b0;
                        ram_we_r          <= 1'b0;
                        ram_re_r          <= 1'b0;
                        ram_addr_r        <= ram_addr_r;
                        ram_wdata_r       <= ram_wdata_r;
                        cmd_tag_r         <= '0;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_addr_r <= '0;
                    init_done_r <= 1'b0;
                    ram_cs_r    <= 1'b0;
                    ram_we_r    <= 1'b0;
                    ram_re_r    <= 1'b0;
                    ram_addr_r  <= '0;
                    ram_wdata_r <= '0;
                    cmd_tag_r   <= '0;
                end
            endcase
        end
    end

    // Response pipeline: the tag follows the command through the RAM's
    // registered read, then the data is captured for the tagged port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_tag_r   <= '0;
            rsp_valid_r <= 2'b00;
            rsp_rdata_r <= '0;
        end else begin
            ram_tag_r <= cmd_tag_r;
            if (ram_tag_r.is_read) begin
                rsp_valid_r <= port_onehot(ram_tag_r.port);
                rsp_rdata_r <= ram_rdata;
            end else begin
                rsp_valid_r <= 2'b00;
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign ram_cs    = ram_cs_r;
    assign ram_we    = ram_we_r;
    assign ram_re    = ram_re_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter (ADDR_W=4, DATA_W=8) with a
// behavioural single-port RAM attached to the RAM pins.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_re;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(
        .ADDR_W   (4),
        .DATA_W   (8),
        .INIT_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .init_done (init_done)
    );

    // Behavioural RAM: posedge write, one-cycle registered read.
    logic [7:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        ram_rdata = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_cs && ram_re) ram_rdata <= mem[ram_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write and read enable must never be asserted together.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (ram_we && ram_re) begin
                errors++;
                $display("FAIL we_re_exclusive: got we=1 re=1 expected not both");
            end
        end
    end

    typedef struct {
        logic [1:0] valid;
        logic [1:0] we;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] ready;
        logic       cs;
        logic       wr;
        logic       rd;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [1:0] rsp;
        logic [7:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [1:0] ready, input logic cs,
                                input logic wr, input logic rd,
                                input logic [3:0] addr, input logic [7:0] wdata,
                                input logic [1:0] rsp, input logic [7:0] rdata);
        vec_t v;
        v.valid = valid; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.ready = ready; v.cs = cs; v.wr = wr; v.rd = rd; v.addr = addr;
        v.wdata = wdata; v.rsp = rsp; v.rdata = rdata;
        return v;
    endfunction

    vec_t vecs [17];

    initial begin
        // inputs                                      | ready cs we re addr wdata rsp rdata (after edge)
        vecs[0]  = mk(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00, 2'b01, 1'b1, 1'b1, 1'b0, 4'd3, 8'hA5, 2'b00, 8'h00);
        vecs[1]  = mk(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 2'b00, 8'h00);
        vecs[2]  = mk(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd3, 8'h00, 2'b00, 8'h00);
        vecs[3]  = mk(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd3, 8'h00, 2'b01, 8'hA5);
        vecs[4]  = mk(2'b10, 2'b10, 4'd0, 4'd7, 8'h00, 8'h3C, 2'b10, 1'b1, 1'b1, 1'b0, 4'd7, 8'h3C, 2'b00, 8'hA5);
        vecs[5]  = mk(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 1'b1, 4'd7, 8'h00, 2'b00, 8'hA5);
        vecs[6]  = mk(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd7, 8'h00, 2'b00, 8'hA5);
        vecs[7]  = mk(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd7, 8'h00, 2'b01, 8'h3C);
        vecs[8]  = mk(2'b01, 2'b01, 4'd1, 4'd0, 8'h11, 8'h00, 2'b01, 1'b1, 1'b1, 1'b0, 4'd1, 8'h11, 2'b00, 8'h3C);
        vecs[9]  = mk(2'b10, 2'b10, 4'd0, 4'd2, 8'h00, 8'h22, 2'b10, 1'b1, 1'b1, 1'b0, 4'd2, 8'h22, 2'b00, 8'h3C);
        vecs[10] = mk(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 1'b1, 4'd1, 8'h00, 2'b00, 8'h3C);
        vecs[11] = mk(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b10, 1'b1, 1'b0, 1'b1, 4'd2, 8'h00, 2'b00, 8'h3C);
        vecs[12] = mk(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 1'b1, 4'd1, 8'h00, 2'b01, 8'h11);
        vecs[13] = mk(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b10, 1'b1, 1'b0, 1'b1, 4'd2, 8'h00, 2'b10, 8'h22);
        vecs[14] = mk(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd2, 8'h00, 2'b01, 8'h11);
        vecs[15] = mk(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd2, 8'h00, 2'b10, 8'h22);
        vecs[16] = mk(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd2, 8'h00, 2'b00, 8'h22);

        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = 8'h00;
        req_wdata = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready",     32'(req_ready), 32'd0);
        check("rst_ram_cs",    32'(ram_cs),    32'd0);
        check("rst_ram_addr",  32'(ram_addr),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        // Init sweep with both ports requesting: no accepts until it ends
        rst_n     = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) req_valid = 2'b00;
            #1;
            check("init_cs",    32'(ram_cs),    32'd1);
            check("init_we",    32'(ram_we),    32'd1);
            check("init_re",    32'(ram_re),    32'd0);
            check("init_addr",  32'(ram_addr),  32'(i));
            check("init_wdata", 32'(ram_wdata), 32'd0);
            check("init_ready", 32'(req_ready), 32'd0);
            check("init_done_low", 32'(init_done), 32'd0);
        end
        @(negedge clk);
        check("init_done_high", 32'(init_done), 32'd1);
        check("init_end_cs",    32'(ram_cs),    32'd0);
        check("init_mem0",      32'(mem[0]),    32'd0);
        check("init_mem15",     32'(mem[15]),   32'd0);

        // Table-driven traffic
        for (int r = 0; r < 17; r++) begin
            req_valid = vecs[r].valid;
            req_we    = vecs[r].we;
            req_addr  = {vecs[r].a1, vecs[r].a0};
            req_wdata = {vecs[r].d1, vecs[r].d0};
            #1;
            check($sformatf("v%0d_ready", r), 32'(req_ready), 32'(vecs[r].ready));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_cs", r),    32'(ram_cs),    32'(vecs[r].cs));
            check($sformatf("v%0d_we", r),    32'(ram_we),    32'(vecs[r].wr));
            check($sformatf("v%0d_re", r),    32'(ram_re),    32'(vecs[r].rd));
            check($sformatf("v%0d_addr", r),  32'(ram_addr),  32'(vecs[r].addr));
            check($sformatf("v%0d_wdata", r), 32'(ram_wdata), 32'(vecs[r].wdata));
            check($sformatf("v%0d_rsp", r),   32'(rsp_valid), 32'(vecs[r].rsp));
            check($sformatf("v%0d_rdata", r), 32'(rsp_rdata), 32'(vecs[r].rdata));
        end

        // Mid-operation reset: read accepted, reset before its response
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = 8'h03;
        req_wdata = 16'h0000;
        #1;
        check("mr_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        check("mr_re_issued", 32'(ram_re), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mr_cs",        32'(ram_cs),    32'd0);
        check("mr_re",        32'(ram_re),    32'd0);
        check("mr_addr",      32'(ram_addr),  32'd0);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("mr_init_done", 32'(init_done), 32'd0);
        check("mr_ready0",    32'(req_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("mr_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mr_sweep_cs",   32'(ram_cs),    32'd1);
            check("mr_sweep_we",   32'(ram_we),    32'd1);
            check("mr_sweep_addr", 32'(ram_addr),  32'(i));
            check("mr_sweep_rsp",  32'(rsp_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle registered read, posedge write) between two requesters, port 0 and port 1.
- Round-robin arbitration with a valid/ready request handshake and a fixed-latency read response.
- After every reset, an init FSM sweeps and clears the whole RAM before any request is accepted.
- Sits between the two client blocks and the RAM instance; it is the only driver of the RAM control pins.

Parameters:
- ADDR_W, 10, address width; RAM depth = 2**ADDR_W.
- DATA_W, 8, data word width.
- INIT_VAL, 0, word written to every location during init.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port accept; at most one bit high.
- req_we  in  2  per-port op: 1 = write, 0 = read.
- req_addr  in  2*ADDR_W  per-port address; port i in slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-port write data, sliced the same way.
- rsp_valid  out  2  one-cycle read-data-valid pulse per port.
- rsp_rdata  out  DATA_W  read data, valid when any rsp_valid bit is high.
- ram_cs  out  1  RAM chip select, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_re  out  1  RAM read enable, registered.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- ram_rdata  in  DATA_W  RAM registered read data.
- init_done  out  1  high once the clear sweep has completed.

Behaviour:
- Reset (async assert, sync release by clk): every output is 0, state = INIT, init_addr = 0, prio = 0, all in-flight operations dropped.
- Reset asserted mid-operation: the same values apply immediately and the init sweep restarts from 0.
- FSM has two states, INIT and RUN.
- INIT: each cycle, issue a write of INIT_VAL to init_addr, then increment init_addr. req_ready stays 00.
- INIT -> RUN: on the cycle the write to address 2**ADDR_W-1 is issued. init_done rises on the following cycle.
- RUN: the grant is combinational from req_valid and prio.
  - Only one port valid: that port is granted.
  - Both valid: port prio is granted.
  - req_ready = one-hot grant. A transfer occurs when valid & ready are both high.
  - After any transfer, prio <= ~granted_port.
  - Requesters must not make req_valid depend on req_ready. A requester must hold addr/data/we stable while valid is high and ready is low.
- Command stage: the transfer at edge k loads the RAM command registers, which are driven during cycle k+1.
  - ram_cs = 1; ram_we = req_we; ram_re = ~req_we; ram_addr and ram_wdata come from the granted port.
  - With no transfer, ram_cs, ram_we and ram_re are 0. ram_we and ram_re are never both 1.
- The RAM executes at edge k+1.
- Read response:
  - A tag (port id, is_read) is pipelined alongside the command.
  - At edge k+2: rsp_rdata <= ram_rdata and rsp_valid[tag] <= 1 for one cycle.
  - Read latency is 2 clocks from accept to rsp_valid.
  - There is no response backpressure; the requester must take the data.
- Writes produce no response.
- Throughput: one operation per cycle. Back-to-back operations to the same address are ordered: a read accepted one cycle after a write to the same address returns the new data.
- An address-width mismatch cannot occur; address wrap is not applicable.

Decomposition:
- Package ram_arb_pkg holds:
  - the state enum (INIT, RUN);
  - the port-index width constant;
  - the tag struct {port, is_read}.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with its prio register.
- The FSM, command registers and response pipeline stay in the top module.

Test Plan:
- Init sweep (ADDR_W=4): release rst_n. Expect 16 consecutive writes of 0 to addresses 0..15, req_ready=00 throughout, init_done high at cycle 17.
- Single port: port 0 writes 0xA5 to addr 3, then reads addr 3. Expect rsp_valid=01 exactly 2 clocks after the read accept, with rsp_rdata=0xA5.
- Contention: both ports hold valid reads continuously (port 0 addr 1, port 1 addr 2). Expect accepts to alternate 0,1,0,1 starting with port 0, and rsp_valid to alternate correspondingly.
- Write-then-read: port 1 writes 0x3C to addr 7; port 0 reads addr 7 on the next cycle. Expect rsp_rdata=0x3C on port 0.
- Stall: port 1 is valid while port 0 is granted. Expect port 1's addr/data unchanged until its ready, and ram_we/ram_re never both 1.
- Mid-operation reset: drop rst_n one cycle after a read accept. Expect all outputs 0 immediately, no rsp_valid afterwards, and the init sweep restarting at addr 0.
